// File: rtl/spi_reg_controller.sv
// SPI mode-0 master issuing one 16-bit register read/write frame per request.
// Frame = {rw, addr[6:0], data[7:0]}, MSB first; read data is taken from the last 8 bits shifted in.
module spi_reg_controller #(
  parameter int DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       sclk,
  output logic       cs_n,
  output logic       mosi,
  input  logic       miso
);

  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, GAP} state_t;

  localparam logic [7:0] DIV_M1 = 8'(DIV - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic [4:0]  bitcnt;
  logic [14:0] tx;
  logic [7:0]  rx;
  logic        rw_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      bitcnt <= '0;
      tx     <= '0;
      rx     <= '0;
      rw_q   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      rdata  <= '0;
      sclk   <= 1'b0;
      cs_n   <= 1'b1;
      mosi   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            tx     <= {addr, (rw ? wdata : 8'h00)};
            rw_q   <= rw;
            mosi   <= rw;
            cs_n   <= 1'b0;
            busy   <= 1'b1;
            cnt    <= DIV_M1;
            bitcnt <= '0;
            state  <= LEAD;
          end
        end
        LEAD: begin
          if (cnt == 8'd0) begin
            cnt    <= DIV_M1;
            sclk   <= 1'b1;
            rx     <= {rx[6:0], miso};
            bitcnt <= bitcnt + 5'd1;
            state  <= SHIFT;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        SHIFT: begin
          if (cnt == 8'd0) begin
            cnt <= DIV_M1;
            if (sclk) begin
              // falling edge: present the next bit, or finish after the 16th
              sclk <= 1'b0;
              if (bitcnt == 5'd16) begin
                mosi  <= 1'b0;
                state <= TRAIL;
              end else begin
                mosi <= tx[14];
                tx   <= {tx[13:0], 1'b0};
              end
            end else begin
              sclk   <= 1'b1;
              rx     <= {rx[6:0], miso};
              bitcnt <= bitcnt + 5'd1;
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        TRAIL: begin
          if (cnt == 8'd0) begin
            cnt   <= DIV_M1;
            cs_n  <= 1'b1;
            done  <= 1'b1;
            if (!rw_q) rdata <= rx;
            state <= GAP;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        GAP: begin
          if (cnt == 8'd0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_controller.sv
// Bench for spi_reg_controller: DIV=4 and DIV=1 instances, each with a behavioural mode-0 peripheral.
module tb_spi_reg_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start4, start1, rw, miso4, miso1;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic       busy4, done4, sclk4, cs4, mosi4;
  logic       busy1, done1, sclk1, cs1, mosi1;
  logic [7:0] rdata4, rdata1;

  spi_reg_controller #(.DIV(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .rw(rw), .addr(addr), .wdata(wdata),
    .busy(busy4), .done(done4), .rdata(rdata4), .sclk(sclk4), .cs_n(cs4),
    .mosi(mosi4), .miso(miso4));

  spi_reg_controller #(.DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .rw(rw), .addr(addr), .wdata(wdata),
    .busy(busy1), .done(done1), .rdata(rdata1), .sclk(sclk1), .cs_n(cs1),
    .mosi(mosi1), .miso(miso1));

  // peripheral models: load response at CS fall, shift out on SCLK falls, capture MOSI on rises
  logic [15:0] resp4, resp1, msr4, msr1, cap4, cap1;
  int nrise4, nrise1;
  always @(negedge cs4) begin msr4 = resp4; miso4 = msr4[15]; cap4 = '0; nrise4 = 0; end
  always @(posedge sclk4) begin cap4 = {cap4[14:0], mosi4}; nrise4++; end
  always @(negedge sclk4) if (!cs4) begin msr4 = msr4 << 1; miso4 = msr4[15]; end
  always @(negedge cs1) begin msr1 = resp1; miso1 = msr1[15]; cap1 = '0; nrise1 = 0; end
  always @(posedge sclk1) begin cap1 = {cap1[14:0], mosi1}; nrise1++; end
  always @(negedge sclk1) if (!cs1) begin msr1 = msr1 << 1; miso1 = msr1[15]; end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rw;
    logic [6:0]  addr;
    logic [7:0]  wdata;
    logic [15:0] resp;
    logic [15:0] exp_mosi;
    logic [7:0]  exp_rdata;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int bad;
    vecs[0] = '{1'b1, 7'h05, 8'hA5, 16'h0000, 16'h85A5, 8'h00};
    vecs[1] = '{1'b0, 7'h12, 8'hEE, 16'h003C, 16'h1200, 8'h3C};
    vecs[2] = '{1'b1, 7'h7F, 8'hFF, 16'h1234, 16'hFFFF, 8'h3C};
    vecs[3] = '{1'b0, 7'h00, 8'h77, 16'hFF5A, 16'h0000, 8'h5A};
    vecs[4] = '{1'b1, 7'h2A, 8'h81, 16'h0000, 16'hAA81, 8'h5A};

    rst_n = 1'b0; start4 = 1'b0; start1 = 1'b0; rw = 1'b0; addr = '0; wdata = '0;
    miso4 = 1'b0; miso1 = 1'b0; resp4 = '0; resp1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    bad = 0;
    for (int t = 0; t < 100; t++) begin
      @(posedge clk); #1;
      if (cs4 !== 1'b1 || sclk4 !== 1'b0 || mosi4 !== 1'b0 || busy4 !== 1'b0 ||
          done4 !== 1'b0 || rdata4 !== 8'h00) bad++;
      if (cs1 !== 1'b1 || sclk1 !== 1'b0 || busy1 !== 1'b0 || done1 !== 1'b0) bad++;
    end
    check("reset_idle_outputs", bad, 0);
    check("reset_rdata", rdata4, 8'h00);

    // table-driven single frames at DIV=4
    for (int v = 0; v < 5; v++) begin
      int t_done, t_bfall, ndone, shigh, csl;
      logic [7:0] rd_done;
      logic cs_done;
      @(negedge clk);
      rw = vecs[v].rw; addr = vecs[v].addr; wdata = vecs[v].wdata;
      resp4 = vecs[v].resp; start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
      rw = ~rw; addr = ~addr; wdata = ~wdata;  // post-acceptance changes must not matter
      check($sformatf("v%0d_e0_cs_busy_mosi", v), {cs4, busy4, sclk4, mosi4},
            {1'b0, 1'b1, 1'b0, vecs[v].rw});
      t_done = -1; t_bfall = -1; ndone = 0; shigh = 0; csl = 1; rd_done = 'x; cs_done = 1'bx;
      for (int t = 1; t <= 150; t++) begin
        @(posedge clk); #1;
        if (done4) begin
          ndone++;
          if (t_done < 0) begin t_done = t; rd_done = rdata4; cs_done = cs4; end
        end
        if (!cs4) csl++;
        if (sclk4) shigh++;
        if (!busy4 && t_bfall < 0) t_bfall = t;
      end
      check($sformatf("v%0d_done_time", v), t_done, 132);
      check($sformatf("v%0d_cs_at_done", v), cs_done, 1'b1);
      check($sformatf("v%0d_done_count", v), ndone, 1);
      check($sformatf("v%0d_busy_fall", v), t_bfall, 136);
      check($sformatf("v%0d_cs_low_cycles", v), csl, 132);
      check($sformatf("v%0d_sclk_high_cycles", v), shigh, 64);
      check($sformatf("v%0d_sclk_rises", v), nrise4, 16);
      check($sformatf("v%0d_mosi_frame", v), cap4, vecs[v].exp_mosi);
      check($sformatf("v%0d_rdata", v), rd_done, vecs[v].exp_rdata);
    end

    // back-to-back: start held for three frames
    begin
      int nd, blr, csr;
      bit bseen, cseen;
      int bl_runs[$], cs_runs[$];
      nd = 0; blr = 0; csr = 0; bseen = 0; cseen = 0;
      @(negedge clk);
      rw = 1'b0; addr = 7'h03; resp4 = 16'h0099; start4 = 1'b1;
      for (int t = 0; t < 600 && !(nd == 3 && !busy4); t++) begin
        @(posedge clk); #1;
        if (done4) begin nd++; if (nd == 3) start4 = 1'b0; end
        if (busy4) begin
          if (bseen && blr > 0) bl_runs.push_back(blr);
          blr = 0; bseen = 1;
        end else if (bseen) blr++;
        if (!cs4) begin
          if (cseen && csr > 0) cs_runs.push_back(csr);
          csr = 0; cseen = 1;
        end else if (cseen) csr++;
      end
      start4 = 1'b0;
      check("b2b_frames", nd, 3);
      check("b2b_busy_gaps", bl_runs.size(), 2);
      check("b2b_busy_gap0", bl_runs.size() > 0 ? bl_runs[0] : -1, 1);
      check("b2b_busy_gap1", bl_runs.size() > 1 ? bl_runs[1] : -1, 1);
      check("b2b_cs_gaps", cs_runs.size(), 2);
      check("b2b_cs_gap0", cs_runs.size() > 0 ? cs_runs[0] : -1, 5);
      check("b2b_cs_gap1", cs_runs.size() > 1 ? cs_runs[1] : -1, 5);
      check("b2b_rdata", rdata4, 8'h99);
      repeat (10) @(posedge clk);
      #1;
      check("b2b_no_fourth", busy4, 1'b0);
    end

    // start pulses mid-frame are ignored
    begin
      int ndone;
      ndone = 0;
      @(negedge clk);
      rw = 1'b0; addr = 7'h12; resp4 = 16'h0066; start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
      for (int t = 1; t <= 150; t++) begin
        @(posedge clk); #1;
        if (done4) ndone++;
        if (t == 50 || t == 51 || t == 90 || t == 133) begin
          start4 = 1'b1; rw = 1'b1; addr = 7'h7F; wdata = 8'hFF;
        end else start4 = 1'b0;
      end
      check("ign_done_count", ndone, 1);
      check("ign_mosi_frame", cap4, 16'h1200);
      check("ign_rdata", rdata4, 8'h66);
      check("ign_idle_after", {busy4, cs4}, {1'b0, 1'b1});
    end

    // reset mid-frame
    begin
      int ndone;
      ndone = 0;
      @(negedge clk);
      rw = 1'b1; addr = 7'h05; wdata = 8'h11; start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      check("rst_mid_cs_low_before", cs4, 1'b0);
      rst_n = 1'b0;
      #1;
      check("rst_mid_outputs", {cs4, sclk4, mosi4, busy4, done4}, 5'b10000);
      check("rst_mid_rdata", rdata4, 8'h00);
      for (int t = 0; t < 5; t++) begin
        @(posedge clk); #1;
        if (done4) ndone++;
      end
      @(negedge clk) rst_n = 1'b1;
      for (int t = 0; t < 20; t++) begin
        @(posedge clk); #1;
        if (done4) ndone++;
      end
      check("rst_mid_no_done", ndone, 0);
      check("rst_mid_stays_idle", {busy4, cs4}, {1'b0, 1'b1});
    end

    // DIV=1 read
    begin
      int t_done, t_bfall, shigh;
      logic [7:0] rd_done;
      t_done = -1; t_bfall = -1; shigh = 0; rd_done = 'x;
      @(negedge clk);
      rw = 1'b0; addr = 7'h55; resp1 = 16'h00C3; start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      check("d1_e0", {cs1, busy1, sclk1, mosi1}, 4'b0100);
      for (int t = 1; t <= 45; t++) begin
        @(posedge clk); #1;
        if (done1 && t_done < 0) begin t_done = t; rd_done = rdata1; end
        if (sclk1) shigh++;
        if (!busy1 && t_bfall < 0) t_bfall = t;
      end
      check("d1_done_time", t_done, 33);
      check("d1_busy_fall", t_bfall, 34);
      check("d1_mosi_frame", cap1, 16'h5500);
      check("d1_rdata", rd_done, 8'hC3);
      check("d1_sclk_rises", nrise1, 16);
      check("d1_sclk_high_cycles", shigh, 16);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
